// File: rtl/key_matrix_scan.sv
// Matrix keypad scanner. Debounces press and release and scans the rows to
// locate the key. Reports single presses, releases, multi-key presses and
// auto-repeats as one-cycle registered pulses.
module key_matrix_scan #(
  parameter int unsigned ROW_NUM    = 4,
  parameter int unsigned COL_NUM    = 4,
  parameter int unsigned CODE_W     = 4,
  parameter int unsigned DEB_CYC    = 1000000,
  parameter int unsigned ROW_SETTLE = 16,
  parameter int unsigned REPEAT_EN  = 1,
  parameter int unsigned REPEAT_DLY = 25000000,
  parameter int unsigned REPEAT_PER = 5000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COL_NUM-1:0] key_col,
  output logic [ROW_NUM-1:0] key_row,
  output logic [CODE_W-1:0]  key_code,
  output logic               key_vld,
  output logic               key_rpt,
  output logic               key_rel,
  output logic               key_multi
);

  localparam int unsigned DEB_W   = $clog2(DEB_CYC + 1);
  localparam int unsigned SET_W   = (ROW_SETTLE > 0) ? $clog2(ROW_SETTLE + 1) : 1;
  localparam int unsigned ROW_W   = $clog2(ROW_NUM);
  localparam int unsigned COL_W   = $clog2(COL_NUM);
  localparam int unsigned RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYC - 1);
  localparam logic [SET_W-1:0] SET_LAST  = SET_W'(ROW_SETTLE);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROW_NUM - 1);
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DLY - 1);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PER - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EVAL,
    HOLD
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [COL_NUM-1:0] r_col_m;
  logic [COL_NUM-1:0] r_col_s;

  logic [DEB_W-1:0]   r_deb_cnt,   w_deb_cnt_nxt;
  logic [DEB_W-1:0]   r_rel_cnt,   w_rel_cnt_nxt;
  logic [SET_W-1:0]   r_set_cnt,   w_set_cnt_nxt;
  logic [ROW_W-1:0]   r_row_idx,   w_row_idx_nxt;
  logic [1:0]         r_hits,      w_hits_nxt;
  logic [CODE_W-1:0]  r_cand,      w_cand_nxt;
  logic               r_reported,  w_reported_nxt;
  logic [RPT_W-1:0]   r_rpt_cnt,   w_rpt_cnt_nxt;
  logic               r_rpt_first, w_rpt_first_nxt;

  logic [ROW_NUM-1:0] r_key_row,   w_key_row_nxt;
  logic [CODE_W-1:0]  r_key_code,  w_key_code_nxt;
  logic               r_key_vld,   w_key_vld_nxt;
  logic               r_key_rpt,   w_key_rpt_nxt;
  logic               r_key_rel,   w_key_rel_nxt;
  logic               r_key_multi, w_key_multi_nxt;

  logic               w_col_idle;
  logic [3:0]         w_zero_cnt;
  logic [COL_W-1:0]   w_first_col;
  logic [CODE_W-1:0]  w_hit_code;
  logic [3:0]         w_hits_sum;
  logic [1:0]         w_hits_sat;
  logic               w_rel_done;
  logic               w_rpt_hit;

  assign key_row   = r_key_row;
  assign key_code  = r_key_code;
  assign key_vld   = r_key_vld;
  assign key_rpt   = r_key_rpt;
  assign key_rel   = r_key_rel;
  assign key_multi = r_key_multi;

  // Two-flop synchroniser for the asynchronous column lines (idle = all ones).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col_m <= '1;
      r_col_s <= '1;
    end else begin
      r_col_m <= key_col;
      r_col_s <= r_col_m;
    end
  end

  // Count pressed columns in the current sample and find the lowest one.
  always_comb begin
    w_zero_cnt  = '0;
    w_first_col = '0;
    for (int unsigned c = COL_NUM; c > 0; c--) begin
      if (!r_col_s[COL_W'(c - 1)]) begin
        w_zero_cnt  = w_zero_cnt + 4'd1;
        w_first_col = COL_W'(c - 1);
      end
    end
  end

  // Derived sample terms: key code of the first hit, saturating hit total.
  always_comb begin
    w_col_idle = &r_col_s;
    w_hit_code = CODE_W'(32'(r_row_idx) * COL_NUM + 32'(w_first_col));
    w_hits_sum = 4'(r_hits) + w_zero_cnt;
    w_hits_sat = (w_hits_sum >= 4'd2) ? 2'd2 : w_hits_sum[1:0];
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, counter and output-pulse logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_deb_cnt_nxt   = r_deb_cnt;
    w_rel_cnt_nxt   = r_rel_cnt;
    w_set_cnt_nxt   = r_set_cnt;
    w_row_idx_nxt   = r_row_idx;
    w_hits_nxt      = r_hits;
    w_cand_nxt      = r_cand;
    w_reported_nxt  = r_reported;
    w_rpt_cnt_nxt   = r_rpt_cnt;
    w_rpt_first_nxt = r_rpt_first;
    w_key_code_nxt  = r_key_code;
    w_key_vld_nxt   = 1'b0;
    w_key_rpt_nxt   = 1'b0;
    w_key_rel_nxt   = 1'b0;
    w_key_multi_nxt = 1'b0;
    w_rel_done      = 1'b0;
    w_rpt_hit       = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_col_idle) begin
          w_deb_cnt_nxt = '0;
        end else if (r_deb_cnt == DEB_LAST) begin
          w_deb_cnt_nxt = '0;
          w_set_cnt_nxt = '0;
          w_row_idx_nxt = '0;
          w_hits_nxt    = '0;
          w_state_nxt   = SCAN;
        end else begin
          w_deb_cnt_nxt = r_deb_cnt + 1'b1;
        end
      end

      SCAN: begin
        if (r_set_cnt == SET_LAST) begin
          if (r_hits == 2'd0 && w_zero_cnt != 4'd0) begin
            w_cand_nxt = w_hit_code;
          end
          w_hits_nxt    = w_hits_sat;
          w_set_cnt_nxt = '0;
          if (r_row_idx == ROW_LAST) begin
            w_state_nxt = EVAL;
          end else begin
            w_row_idx_nxt = r_row_idx + 1'b1;
          end
        end else begin
          w_set_cnt_nxt = r_set_cnt + 1'b1;
        end
      end

      EVAL: begin
        w_rel_cnt_nxt   = '0;
        w_rpt_cnt_nxt   = '0;
        w_rpt_first_nxt = 1'b1;
        if (r_hits == 2'd1) begin
          w_key_code_nxt = r_cand;
          w_key_vld_nxt  = 1'b1;
          w_reported_nxt = 1'b1;
          w_state_nxt    = HOLD;
        end else if (r_hits != 2'd0) begin
          w_key_multi_nxt = 1'b1;
          w_reported_nxt  = 1'b0;
          w_state_nxt     = HOLD;
        end else begin
          w_state_nxt = IDLE;
        end
      end

      HOLD: begin
        if (!w_col_idle) begin
          w_rel_cnt_nxt = '0;
        end else if (r_rel_cnt == DEB_LAST) begin
          w_rel_cnt_nxt = '0;
          w_rel_done    = 1'b1;
          w_key_rel_nxt = r_reported;
          w_state_nxt   = IDLE;
        end else begin
          w_rel_cnt_nxt = r_rel_cnt + 1'b1;
        end

        // Repeat timer runs independently of release bounces; a repeat that
        // lands on the release-complete cycle is dropped.
        if (REPEAT_EN != 0 && r_reported) begin
          w_rpt_hit = (r_rpt_cnt == (r_rpt_first ? RPT_FIRST : RPT_NEXT));
          if (w_rpt_hit) begin
            w_rpt_cnt_nxt   = '0;
            w_rpt_first_nxt = 1'b0;
            if (!w_rel_done) begin
              w_key_vld_nxt = 1'b1;
              w_key_rpt_nxt = 1'b1;
            end
          end else begin
            w_rpt_cnt_nxt = r_rpt_cnt + 1'b1;
          end
        end
      end

      default: w_state_nxt = IDLE;
    endcase

    w_key_row_nxt = (w_state_nxt == SCAN) ? ~(ROW_NUM'(1) << w_row_idx_nxt) : '0;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_deb_cnt   <= '0;
      r_rel_cnt   <= '0;
      r_set_cnt   <= '0;
      r_row_idx   <= '0;
      r_hits      <= '0;
      r_cand      <= '0;
      r_reported  <= 1'b0;
      r_rpt_cnt   <= '0;
      r_rpt_first <= 1'b1;
      r_key_row   <= '0;
      r_key_code  <= '0;
      r_key_vld   <= 1'b0;
      r_key_rpt   <= 1'b0;
      r_key_rel   <= 1'b0;
      r_key_multi <= 1'b0;
    end else begin
      r_deb_cnt   <= w_deb_cnt_nxt;
      r_rel_cnt   <= w_rel_cnt_nxt;
      r_set_cnt   <= w_set_cnt_nxt;
      r_row_idx   <= w_row_idx_nxt;
      r_hits      <= w_hits_nxt;
      r_cand      <= w_cand_nxt;
      r_reported  <= w_reported_nxt;
      r_rpt_cnt   <= w_rpt_cnt_nxt;
      r_rpt_first <= w_rpt_first_nxt;
      r_key_row   <= w_key_row_nxt;
      r_key_code  <= w_key_code_nxt;
      r_key_vld   <= w_key_vld_nxt;
      r_key_rpt   <= w_key_rpt_nxt;
      r_key_rel   <= w_key_rel_nxt;
      r_key_multi <= w_key_multi_nxt;
    end
  end

endmodule

// File: tb/tb_key_matrix_scan.sv
// Directed bench for key_matrix_scan: 4x4 with and without repeat, plus 3x5.
module tb_key_matrix_scan;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;

  // Cycle count; read on the falling edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Keypad models: a pressed key (r,c) pulls column c low while row r is low.
  function automatic logic [3:0] pad44(input logic [15:0] k, input logic [3:0] row);
    logic [3:0] col;
    col = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (k[r*4+c] && !row[r]) col[c] = 1'b0;
    return col;
  endfunction

  function automatic logic [4:0] pad35(input logic [14:0] k, input logic [2:0] row);
    logic [4:0] col;
    col = '1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++)
        if (k[r*5+c] && !row[r]) col[c] = 1'b0;
    return col;
  endfunction

  logic [15:0] keys44 = '0;
  logic [14:0] keys35 = '0;

  logic [3:0] col_a, row_a, code_a;
  logic       vld_a, rpt_a, rel_a, multi_a;
  logic [3:0] col_b, row_b, code_b;
  logic       vld_b, rpt_b, rel_b, multi_b;
  logic [4:0] col_c;
  logic [2:0] row_c;
  logic [3:0] code_c;
  logic       vld_c, rpt_c, rel_c, multi_c;

  assign col_a = pad44(keys44, row_a);
  assign col_b = pad44(keys44, row_b);
  assign col_c = pad35(keys35, row_c);

  key_matrix_scan #(.ROW_NUM(4), .COL_NUM(4), .CODE_W(4), .DEB_CYC(8), .ROW_SETTLE(2),
                    .REPEAT_EN(1), .REPEAT_DLY(40), .REPEAT_PER(10)) dut (
    .clk(clk), .rst(rst), .key_col(col_a), .key_row(row_a), .key_code(code_a),
    .key_vld(vld_a), .key_rpt(rpt_a), .key_rel(rel_a), .key_multi(multi_a));

  key_matrix_scan #(.ROW_NUM(4), .COL_NUM(4), .CODE_W(4), .DEB_CYC(8), .ROW_SETTLE(2),
                    .REPEAT_EN(0), .REPEAT_DLY(40), .REPEAT_PER(10)) dut_nr (
    .clk(clk), .rst(rst), .key_col(col_b), .key_row(row_b), .key_code(code_b),
    .key_vld(vld_b), .key_rpt(rpt_b), .key_rel(rel_b), .key_multi(multi_b));

  key_matrix_scan #(.ROW_NUM(3), .COL_NUM(5), .CODE_W(4), .DEB_CYC(8), .ROW_SETTLE(2),
                    .REPEAT_EN(1), .REPEAT_DLY(40), .REPEAT_PER(10)) dut35 (
    .clk(clk), .rst(rst), .key_col(col_c), .key_row(row_c), .key_code(code_c),
    .key_vld(vld_c), .key_rpt(rpt_c), .key_rel(rel_c), .key_multi(multi_c));

  // Event logs (only the monitors write them).
  int vld_cyc_a[$], vld_code_a[$], vld_rpt_a[$];
  int rel_cyc_a[$], rel_code_a[$], multi_cyc_a[$], scan_cyc_a[$];
  int overlap_a = 0;
  logic [3:0] prev_row_a = '0;
  int n_vld_b = 0, n_rpt_b = 0, n_rel_b = 0;
  int vld_cyc_c[$], vld_code_c[$], rel_code_c[$], row_val_c[$], row_cyc_c[$];
  logic [2:0] prev_row_c = '0;

  always @(negedge clk) begin
    if (vld_a) begin
      vld_cyc_a.push_back(cyc);
      vld_code_a.push_back(int'(code_a));
      vld_rpt_a.push_back(int'(rpt_a));
    end
    if (rel_a) begin
      rel_cyc_a.push_back(cyc);
      rel_code_a.push_back(int'(code_a));
    end
    if (multi_a) multi_cyc_a.push_back(cyc);
    if ((int'(vld_a) + int'(rel_a) + int'(multi_a)) > 1) overlap_a++;
    if (row_a != 4'b0 && prev_row_a == 4'b0) scan_cyc_a.push_back(cyc);
    prev_row_a = row_a;
  end

  always @(negedge clk) begin
    if (vld_b) n_vld_b++;
    if (rpt_b) n_rpt_b++;
    if (rel_b) n_rel_b++;
  end

  always @(negedge clk) begin
    if (vld_c) begin
      vld_cyc_c.push_back(cyc);
      vld_code_c.push_back(int'(code_c));
    end
    if (rel_c) rel_code_c.push_back(int'(code_c));
    if (row_c != prev_row_c && row_c != 3'b0) begin
      row_val_c.push_back(int'(row_c));
      row_cyc_c.push_back(cyc);
    end
    prev_row_c = row_c;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int qat(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [15:0] keys;
    int          multi;
    int          code;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int b_vld, b_rel, b_mul, b_scan, b_row;
    int t0, t1, t2, v;
    int bn_vld, bn_rpt, bn_rel;

    tbl[0] = '{16'h0200, 0, 9};   // (2,1)
    tbl[1] = '{16'h0080, 0, 7};   // (1,3)
    tbl[2] = '{16'h0001, 0, 0};   // (0,0)
    tbl[3] = '{16'h8000, 0, 15};  // (3,3)
    tbl[4] = '{16'h0020, 0, 5};   // (1,1)
    tbl[5] = '{16'h8001, 1, 0};   // (0,0)+(3,3)
    tbl[6] = '{16'h0050, 1, 0};   // (1,0)+(1,2), same row

    // Reset state
    tick(2);
    check("rst_row",   int'(row_a),   0);
    check("rst_code",  int'(code_a),  0);
    check("rst_vld",   int'(vld_a),   0);
    check("rst_rpt",   int'(rpt_a),   0);
    check("rst_rel",   int'(rel_a),   0);
    check("rst_multi", int'(multi_a), 0);
    rst = 1'b0;
    tick(3);

    // Table of single and multi-key presses on the 4x4 scanner
    for (int i = 0; i < 7; i++) begin
      b_vld = vld_cyc_a.size(); b_rel = rel_cyc_a.size();
      b_mul = multi_cyc_a.size(); b_scan = scan_cyc_a.size();
      keys44 = tbl[i].keys;
      t0 = cyc;
      tick(30);
      keys44 = '0;
      t1 = cyc;
      tick(20);
      if (tbl[i].multi == 0) begin
        check($sformatf("v%0d_nvld", i), vld_cyc_a.size() - b_vld, 1);
        check($sformatf("v%0d_code", i), qat(vld_code_a, b_vld), tbl[i].code);
        check($sformatf("v%0d_rpt", i), qat(vld_rpt_a, b_vld), 0);
        check($sformatf("v%0d_lat_press", i), qat(vld_cyc_a, b_vld) - t0, 23);
        check($sformatf("v%0d_lat_scan", i), qat(vld_cyc_a, b_vld) - qat(scan_cyc_a, b_scan), 13);
        check($sformatf("v%0d_nrel", i), rel_cyc_a.size() - b_rel, 1);
        check($sformatf("v%0d_rel_code", i), qat(rel_code_a, b_rel), tbl[i].code);
        check($sformatf("v%0d_rel_lat", i), qat(rel_cyc_a, b_rel) - t1, 10);
        check($sformatf("v%0d_nmulti", i), multi_cyc_a.size() - b_mul, 0);
        check($sformatf("v%0d_code_hold", i), int'(code_a), tbl[i].code);
      end else begin
        check($sformatf("v%0d_nmulti", i), multi_cyc_a.size() - b_mul, 1);
        check($sformatf("v%0d_multi_lat", i), qat(multi_cyc_a, b_mul) - t0, 23);
        check($sformatf("v%0d_nvld", i), vld_cyc_a.size() - b_vld, 0);
        check($sformatf("v%0d_nrel", i), rel_cyc_a.size() - b_rel, 0);
      end
    end

    // Bouncing press never completes debounce
    b_vld = vld_cyc_a.size(); b_rel = rel_cyc_a.size();
    b_mul = multi_cyc_a.size(); b_scan = scan_cyc_a.size();
    for (int k = 0; k < 10; k++) begin
      keys44 = 16'h0200;
      tick(5);
      keys44 = '0;
      tick(3);
    end
    tick(20);
    check("bounce_nvld",   vld_cyc_a.size() - b_vld, 0);
    check("bounce_nrel",   rel_cyc_a.size() - b_rel, 0);
    check("bounce_nmulti", multi_cyc_a.size() - b_mul, 0);
    check("bounce_nscan",  scan_cyc_a.size() - b_scan, 0);

    // Auto-repeat on (1,3); release timed so release completes on a repeat slot
    b_vld = vld_cyc_a.size(); b_rel = rel_cyc_a.size();
    bn_vld = n_vld_b; bn_rpt = n_rpt_b; bn_rel = n_rel_b;
    keys44 = 16'h0080;
    t0 = cyc;
    v = t0 + 23;
    tick(113);
    keys44 = '0;
    tick(30);
    check("rpt_nvld", vld_cyc_a.size() - b_vld, 7);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("rpt%0d_cyc", i), qat(vld_cyc_a, b_vld + i) - v, (i == 0) ? 0 : 30 + 10 * i);
      check($sformatf("rpt%0d_code", i), qat(vld_code_a, b_vld + i), 7);
      check($sformatf("rpt%0d_flag", i), qat(vld_rpt_a, b_vld + i), (i == 0) ? 0 : 1);
    end
    check("rpt_nrel",    rel_cyc_a.size() - b_rel, 1);
    check("rpt_rel_cyc", qat(rel_cyc_a, b_rel) - v, 100);
    check("rpt_rel_code", qat(rel_code_a, b_rel), 7);
    check("norpt_nvld", n_vld_b - bn_vld, 1);
    check("norpt_nrpt", n_rpt_b - bn_rpt, 0);
    check("norpt_nrel", n_rel_b - bn_rel, 1);

    // 3x5 keypad, key (2,4)
    b_vld = vld_cyc_c.size(); b_rel = rel_code_c.size(); b_row = row_val_c.size();
    keys35 = 15'h4000;
    t0 = cyc;
    tick(30);
    keys35 = '0;
    tick(20);
    check("k35_nvld",  vld_cyc_c.size() - b_vld, 1);
    check("k35_code",  qat(vld_code_c, b_vld), 14);
    check("k35_lat",   qat(vld_cyc_c, b_vld) - t0, 20);
    check("k35_nrows", row_val_c.size() - b_row, 3);
    check("k35_row0",  qat(row_val_c, b_row),     3'b110);
    check("k35_row1",  qat(row_val_c, b_row + 1), 3'b101);
    check("k35_row2",  qat(row_val_c, b_row + 2), 3'b011);
    check("k35_slot",  qat(row_cyc_c, b_row + 1) - qat(row_cyc_c, b_row), 3);
    check("k35_nrel",  rel_code_c.size() - b_rel, 1);
    check("k35_rel_code", qat(rel_code_c, b_rel), 14);

    // Reset in the middle of a scan while (1,1) is held
    b_vld = vld_cyc_a.size(); b_rel = rel_cyc_a.size(); b_mul = multi_cyc_a.size();
    keys44 = 16'h0020;
    t0 = cyc;
    tick(13);
    check("mid_scan_row", int'(row_a), 4'b1101);
    rst = 1'b1;
    #1;
    check("rst_async_row", int'(row_a), 0);
    tick(2);
    check("rst_hold_row", int'(row_a), 0);
    rst = 1'b0;
    t2 = cyc;
    tick(40);
    check("rst_nvld",   vld_cyc_a.size() - b_vld, 1);
    check("rst_code5",  qat(vld_code_a, b_vld), 5);
    check("rst_lat",    qat(vld_cyc_a, b_vld) - t2, 23);
    check("rst_nmulti", multi_cyc_a.size() - b_mul, 0);
    keys44 = '0;
    tick(20);
    check("rst_nrel", rel_cyc_a.size() - b_rel, 1);

    check("pulse_overlap", overlap_a, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
